// File: rtl/ecc_apb_reg_bank.sv
// ecc_apb_reg_bank: APB register bank feeding the ECC core with control, data, width, noise and a start pulse
module ecc_apb_reg_bank #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  output logic [1:0]                 ctrl,
  output logic [AMBA_WORD-1:0]       data_in,
  output logic [1:0]                 codeword_width,
  output logic [AMBA_WORD-1:0]       noise,
  output logic                       start,
  output logic                       busy
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state_q, state_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [1:0]           cw_q, cw_d;
  logic [1:0]           errs_q, errs_d;
  logic                 done_q, done_d;
  logic                 start_q, start_d;
  logic [AMBA_WORD-1:0] data_q, data_d;
  logic [AMBA_WORD-1:0] noise_q, noise_d;
  logic [AMBA_WORD-1:0] prdata_q, prdata_d;
  logic [2:0]           idx;
  logic                 sel_ok, wr_en, rd_en, ctrl_wr, finish;
  logic [AMBA_WORD-1:0] rd_mux;
  logic                 unused_addr_lsb;
  assign unused_addr_lsb = ^PADDR[1:0];
  // Address decode, access qualification (writes locked out while busy) and read mux
  always_comb begin
    idx     = PADDR[4:2];
    sel_ok  = PADDR[AMBA_ADDR_WIDTH-1:5] == '0;
    wr_en   = PSEL & PENABLE & PWRITE & sel_ok & (state_q == IDLE);
    rd_en   = PSEL & ~PENABLE & ~PWRITE;
    ctrl_wr = wr_en & (idx == 3'd0) & (PWDATA[1:0] != 2'b11);
    finish  = (state_q == BUSY) & operation_done;
    rd_mux  = !sel_ok      ? '0 :
              idx == 3'd0  ? {{(AMBA_WORD-2){1'b0}}, ctrl_q} :
              idx == 3'd1  ? data_q :
              idx == 3'd2  ? {{(AMBA_WORD-2){1'b0}}, cw_q} :
              idx == 3'd3  ? noise_q :
              idx == 3'd4  ? {{(AMBA_WORD-4){1'b0}}, errs_q, done_q, state_q == BUSY} : '0;
  end
  // Next-state: register writes, launch on accepted CTRL write, completion on operation_done
  always_comb begin
    data_d   = wr_en & (idx == 3'd1) ? PWDATA : data_q;
    cw_d     = wr_en & (idx == 3'd2) & (PWDATA[1:0] != 2'b11) ? PWDATA[1:0] : cw_q;
    noise_d  = wr_en & (idx == 3'd3) ? PWDATA : noise_q;
    ctrl_d   = ctrl_wr ? PWDATA[1:0] : ctrl_q;
    start_d  = ctrl_wr;
    prdata_d = rd_en ? rd_mux : prdata_q;
    errs_d   = finish ? num_of_errors : errs_q;
    done_d   = ctrl_wr ? 1'b0 : finish ? 1'b1 : done_q;
    state_d  = ctrl_wr ? BUSY : finish ? IDLE : state_q;
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      cw_q     <= '0;
      errs_q   <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      noise_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      cw_q     <= cw_d;
      errs_q   <= errs_d;
      done_q   <= done_d;
      start_q  <= start_d;
      data_q   <= data_d;
      noise_q  <= noise_d;
      prdata_q <= prdata_d;
    end
  end
  assign PRDATA         = prdata_q;
  assign ctrl           = ctrl_q;
  assign data_in        = data_q;
  assign codeword_width = cw_q;
  assign noise          = noise_q;
  assign start          = start_q;
  assign busy           = state_q == BUSY;
endmodule

// File: tb/tb_ecc_apb_reg_bank.sv
// tb_ecc_apb_reg_bank: directed self-checking bench for the ECC APB register bank
module tb_ecc_apb_reg_bank;
  logic        clk = 0;
  logic        rst;
  logic [19:0] PADDR;
  logic        PENABLE, PSEL, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        operation_done;
  logic [1:0]  num_of_errors;
  logic [1:0]  ctrl, codeword_width;
  logic [31:0] data_in, noise;
  logic        start, busy;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] rd;
  ecc_apb_reg_bank dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .operation_done(operation_done), .num_of_errors(num_of_errors),
    .ctrl(ctrl), .data_in(data_in), .codeword_width(codeword_width), .noise(noise),
    .start(start), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask
  task automatic apb_read(input logic [19:0] a, output logic [31:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
    tick();
    PENABLE = 1;
    tick();
    d = PRDATA;
    PSEL = 0; PENABLE = 0;
  endtask
  task automatic pulse_done(input logic [1:0] n);
    operation_done = 1; num_of_errors = n;
    tick();
    operation_done = 0; num_of_errors = 0;
  endtask
  initial begin
    rst = 1; PADDR = 0; PENABLE = 0; PSEL = 0; PWRITE = 0; PWDATA = 0;
    operation_done = 0; num_of_errors = 0;
    tick(); tick();
    chk("rst_ctrl", {30'd0, ctrl}, 0);
    chk("rst_data", data_in, 0);
    chk("rst_cw", {30'd0, codeword_width}, 0);
    chk("rst_noise", noise, 0);
    chk("rst_start", {31'd0, start}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_prdata", PRDATA, 0);
    rst = 0;
    apb_read(20'h10, rd); chk("rst_status", rd, 0);
    apb_write(20'h04, 32'hDEADBEEF);
    apb_write(20'h08, 32'h2);
    apb_write(20'h0C, 32'h1);
    chk("start_idle", {31'd0, start}, 0);
    apb_write(20'h00, 32'h1);
    chk("launch_start", {31'd0, start}, 1);
    chk("launch_busy", {31'd0, busy}, 1);
    chk("launch_ctrl", {30'd0, ctrl}, 1);
    chk("data_in", data_in, 32'hDEADBEEF);
    chk("cw", {30'd0, codeword_width}, 2);
    chk("noise", noise, 1);
    tick();
    chk("start_one_cycle", {31'd0, start}, 0);
    chk("busy_hold", {31'd0, busy}, 1);
    apb_write(20'h04, 32'h12345678);
    chk("lockout_data", data_in, 32'hDEADBEEF);
    apb_read(20'h04, rd); chk("lockout_read", rd, 32'hDEADBEEF);
    apb_read(20'h10, rd); chk("status_busy", rd, 32'h1);
    pulse_done(2'd1);
    chk("done_busy", {31'd0, busy}, 0);
    apb_read(20'h10, rd); chk("status_done1", rd, 32'h6);
    apb_write(20'h00, 32'h3);
    chk("rsv_ctrl_start", {31'd0, start}, 0);
    chk("rsv_ctrl_busy", {31'd0, busy}, 0);
    chk("rsv_ctrl", {30'd0, ctrl}, 1);
    apb_write(20'h08, 32'h3);
    chk("rsv_cw", {30'd0, codeword_width}, 2);
    apb_read(20'h14, rd); chk("unmapped_read", rd, 0);
    apb_write(20'h14, 32'hFFFFFFFF);
    apb_write(20'h20, 32'h2);
    chk("upper_addr_start", {31'd0, start}, 0);
    apb_read(20'h00, rd); chk("rd_ctrl", rd, 1);
    apb_read(20'h04, rd); chk("rd_data", rd, 32'hDEADBEEF);
    apb_read(20'h08, rd); chk("rd_cw", rd, 2);
    apb_read(20'h0C, rd); chk("rd_noise", rd, 1);
    apb_read(20'h10, rd); chk("status_after_unmapped", rd, 32'h6);
    apb_write(20'h00, 32'h1);
    chk("relaunch_start", {31'd0, start}, 1);
    apb_read(20'h10, rd); chk("status_sticky_clr", rd, 32'h5);
    pulse_done(2'd2);
    apb_read(20'h10, rd); chk("status_done2", rd, 32'hA);
    apb_write(20'h00, 32'h2);
    chk("launch2_ctrl", {30'd0, ctrl}, 2);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 20'h00; PWDATA = 32'h1;
    tick();
    PENABLE = 1; operation_done = 1; num_of_errors = 2'd3;
    tick();
    PSEL = 0; PENABLE = 0; PWRITE = 0; operation_done = 0; num_of_errors = 0;
    chk("collide_ctrl", {30'd0, ctrl}, 2);
    chk("collide_start", {31'd0, start}, 0);
    chk("collide_busy", {31'd0, busy}, 0);
    apb_read(20'h10, rd); chk("status_done3", rd, 32'hE);
    pulse_done(2'd0);
    apb_read(20'h10, rd); chk("idle_done_ignored", rd, 32'hE);
    apb_write(20'h00, 32'h0);
    chk("launch3_busy", {31'd0, busy}, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_data", data_in, 0);
    chk("midrst_noise", noise, 0);
    pulse_done(2'd1);
    chk("post_rst_busy", {31'd0, busy}, 0);
    apb_read(20'h10, rd); chk("post_rst_status", rd, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
